multi_cycle_cpu: RTL

Parametrised multi-cycle successor to the 8-bit single-cycle computer. It keeps the 16-bit instruction format and the opcode-field control decode, with these changes:
- Datapath width and PC width are parameters.
- Instruction fetch and execute are split across FSM states.
- Data memory is external, behind a req/ready handshake with arbitrary wait states.
- An all-zero instruction word halts the core.

It sits between an external instruction ROM and an external data RAM/bus.

---
 rtl/multi_cycle_cpu_if.sv | 15 +
 rtl/multi_cycle_cpu.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/multi_cycle_cpu_if.sv
// Data-memory handshake bundle between the core (master) and a RAM/bus (slave).
// The request side is held stable by the master until ready is seen high.
interface multi_cycle_cpu_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  req;
  logic                  we;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;

  modport master (output req, we, addr, wdata, input rdata, ready);
  modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle core: 16-bit instruction word, opcode-field control decode,
// eight general registers, handshaked external data memory, halt on 16'h0000.
//
// state | meaning
// FETCH | latch the word at imem_addr (= PC) into IR
// EXEC  | decode IR: ALU write-back, branch/jump, launch data access, or halt
// MEM   | hold the data request until ready; loads write R[DR] on completion
// HALT  | stopped on an all-zero instruction; only reset leaves this state
module multi_cycle_cpu #(
  parameter int DATA_WIDTH = 8,
  parameter int PC_WIDTH   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [15:0]           imem_rdata,
  multi_cycle_cpu_if.master     dmem,
  output logic                  instr_retired,
  output logic                  halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t                state;
  logic [PC_WIDTH-1:0]   pc;
  logic [15:0]           ir;
  logic [DATA_WIDTH-1:0] rf [8];

  logic [6:0]            op;
  logic [2:0]            dr, sa, sb;
  logic                  mb, md, rw, mw, pl, jb, bc;
  logic [3:0]            fs;
  logic                  is_load;
  logic [DATA_WIDTH-1:0] a_op, b_op, alu_f;
  logic                  alu_z, alu_n, br_cond;
  logic [5:0]            br_off;
  logic [PC_WIDTH-1:0]   pc_inc, pc_br;

  assign imem_addr = pc;

  assign op = ir[15:9];
  assign dr = ir[8:6];
  assign sa = ir[5:3];
  assign sb = ir[2:0];

  assign mb      = op[6];
  assign md      = op[4];
  assign rw      = ~op[5];
  assign mw      = op[5] & ~op[6];
  assign pl      = op[5] & op[6];
  assign jb      = op[4];
  assign bc      = op[0];
  assign fs      = {op[3], op[2], op[1], op[0] & ~pl};
  // op[6:4] = 001: memory-data select with a register write and no store
  assign is_load = md & ~op[5] & ~op[6];

  assign a_op = rf[sa];
  assign b_op = mb ? DATA_WIDTH'(ir[2:0]) : rf[sb];

  // Function-select ALU; flags are taken over the full datapath width.
  always_comb begin
    alu_f = a_op;
    case (fs)
      4'h0: alu_f = a_op;
      4'h1: alu_f = a_op + DATA_WIDTH'(1);
      4'h2: alu_f = a_op + b_op;
      4'h3: alu_f = a_op + b_op + DATA_WIDTH'(1);
      4'h4: alu_f = a_op + ~b_op;
      4'h5: alu_f = a_op - b_op;
      4'h6: alu_f = a_op - DATA_WIDTH'(1);
      4'h7: alu_f = a_op;
      4'h8: alu_f = a_op & b_op;
      4'h9: alu_f = a_op | b_op;
      4'hA: alu_f = a_op ^ b_op;
      4'hB: alu_f = ~a_op;
      4'hC: alu_f = b_op;
      4'hD: alu_f = b_op >> 1;
      4'hE: alu_f = b_op << 1;
      default: alu_f = a_op;
    endcase
  end

  assign alu_z   = (alu_f == '0);
  assign alu_n   = alu_f[DATA_WIDTH-1];
  assign br_cond = bc ? alu_n : alu_z;
  assign br_off  = {ir[8:6], ir[2:0]};
  assign pc_inc  = pc + PC_WIDTH'(1);
  // 6-bit signed offset, sign-extended to the PC width; the sum wraps naturally
  assign pc_br   = pc + PC_WIDTH'($signed(br_off));

  // Sequencer, register file, PC and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_FETCH;
      pc            <= '0;
      ir            <= '0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      dmem.req      <= 1'b0;
      dmem.we       <= 1'b0;
      dmem.addr     <= '0;
      dmem.wdata    <= '0;
      instr_retired <= 1'b0;
      halted        <= 1'b0;
    end else begin
      instr_retired <= 1'b0;
      case (state)
        S_FETCH: begin
          ir    <= imem_rdata;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (ir == 16'h0000) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else if (pl) begin
            if (jb) pc <= PC_WIDTH'(a_op);
            else    pc <= br_cond ? pc_br : pc_inc;
            instr_retired <= 1'b1;
            state         <= S_FETCH;
          end else if (mw || is_load) begin
            dmem.req   <= 1'b1;
            dmem.we    <= mw;
            dmem.addr  <= a_op;
            dmem.wdata <= rf[sb];
            state      <= S_MEM;
          end else begin
            if (rw) rf[dr] <= alu_f;
            pc            <= pc_inc;
            instr_retired <= 1'b1;
            state         <= S_FETCH;
          end
        end
        S_MEM: begin
          if (dmem.req && dmem.ready) begin
            if (!dmem.we) rf[dr] <= dmem.rdata;
            dmem.req      <= 1'b0;
            pc            <= pc_inc;
            instr_retired <= 1'b1;
            state         <= S_FETCH;
          end
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
